// File: rtl/button_event_ctrl.sv
// Push-button controller: two-flop synchroniser, per-button debounce FSM,
// sticky press/release flags and a small read/write register block with a level irq.
module button_event_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnDown,
  input  logic        btnUp,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CNT_W   = 22;
  localparam int unsigned EVT_W   = 2 * NUM_BTN;
  localparam int unsigned DATA_W  = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SEL_STATUS = 2'd0;
  localparam logic [1:0] SEL_EVENTS = 2'd1;
  localparam logic [1:0] SEL_IRQ_EN = 2'd2;

  typedef enum logic {
    STABLE   = 1'b0,
    DEBOUNCE = 1'b1
  } db_state_e;

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] sync_c;

  db_state_e          state      [NUM_BTN];
  db_state_e          state_next [NUM_BTN];
  logic [CNT_W-1:0]   cnt        [NUM_BTN];
  logic [CNT_W-1:0]   cnt_next   [NUM_BTN];
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_next;
  logic [NUM_BTN-1:0] press_c;
  logic [NUM_BTN-1:0] release_c;

  logic [EVT_W-1:0]   events;
  logic [EVT_W-1:0]   irq_en;
  logic [EVT_W-1:0]   events_next_c;
  logic [EVT_W-1:0]   irq_en_next_c;
  logic [DATA_W-1:0]  rdata_c;
  logic [1:0]         reg_sel_c;
  logic               rd_events_c;
  logic               wr_irq_en_c;
  logic               unused_bits;

  assign raw_n  = {btnRight, btnLeft, btnUp, btnDown};
  assign sync_c = ~sync2;

  // Synchroniser resets to "released" so no spurious press follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
      level <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      level <= level_next;
    end
  end

  // Debounce: level flips once sync has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
    end
    level_next = level;
    press_c    = '0;
    release_c  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      case (state[i])
        STABLE: begin
          if (sync_c[i] != level[i]) begin
            state_next[i] = DEBOUNCE;
            cnt_next[i]   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (sync_c[i] == level[i]) begin
            state_next[i] = STABLE;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            level_next[i] = ~level[i];
            press_c[i]    = sync_c[i];
            release_c[i]  = ~sync_c[i];
            state_next[i] = STABLE;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_next[i] = STABLE;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

  assign reg_sel_c   = address[3:2];
  assign rd_events_c = ren && (reg_sel_c == SEL_EVENTS);
  assign wr_irq_en_c = wen && (reg_sel_c == SEL_IRQ_EN);
  assign unused_bits = ^{address[31:4], address[1:0], wdata[31:8]};

  // New pulses are OR'd in after the read-clear so a coincident event stays pending
  assign events_next_c = (rd_events_c ? {EVT_W{1'b0}} : events) | {release_c, press_c};
  assign irq_en_next_c = wr_irq_en_c ? wdata[EVT_W-1:0] : irq_en;

  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      SEL_STATUS: rdata_c = DATA_W'(level);
      SEL_EVENTS: rdata_c = DATA_W'(events);
      SEL_IRQ_EN: rdata_c = DATA_W'(irq_en);
      default:    rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      events   <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      events <= events_next_c;
      irq_en <= irq_en_next_c;
      irq    <= |(events_next_c & irq_en_next_c);
      if (ren) begin
        data_out <= rdata_c;
      end
    end
  end

endmodule
